sprite_line_fetcher: RTL

Scanline sprite engine between the VGA controller and the character sprite ROM. During each horizontal blanking interval it fetches the one 32-bit sprite row needed on the next scanline for Pac-Man and for each ghost, and stores it in per-character shadow registers. At the start of the next line it promotes the shadow rows to active registers. During active video it produces registered per-pixel hit flags consumed by the color mapper.

---
 rtl/pacman_pkg.sv | 46 ++++
 rtl/sprite_slot.sv | 91 +++++++++
 rtl/sprite_line_fetcher.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pacman_pkg.sv
// Shared definitions for the Pac-Man video pipeline.
//   - VGA timing constants (640x480 visible inside an 800x525 frame).
//   - Sprite geometry and sprite ROM base addresses.
//   - Direction and line-fetch FSM state enums.
//   - Helpers for next-scanline and sprite-relative offset arithmetic.
package pacman_pkg;

    localparam int unsigned H_ACTIVE    = 640;
    localparam int unsigned H_TOTAL     = 800;
    localparam int unsigned V_ACTIVE    = 480;
    localparam int unsigned V_TOTAL     = 525;
    localparam int unsigned SPRITE_SIZE = 32;

    localparam logic [7:0] SPR_BASE_PAC   = 8'd0;
    localparam logic [7:0] SPR_BASE_GHOST = 8'd128;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_UP    = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StWait  = 2'd2
    } fetch_state_t;

    // Scanline that follows y, wrapping from the last line of the frame to 0.
    function automatic logic [9:0] next_line(input logic [9:0] y);
        return (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
    endfunction

    // Offset of a screen coordinate from a sprite origin, as 11-bit two's complement.
    function automatic logic [10:0] sprite_offset(input logic [9:0] cur,
                                                  input logic [9:0] origin);
        return {1'b0, cur} - {1'b0, origin};
    endfunction

    // Negative offsets read as large unsigned values, so one compare covers 0..31.
    function automatic logic in_sprite(input logic [10:0] off);
        return off < 11'(SPRITE_SIZE);
    endfunction

endpackage

// File: rtl/sprite_slot.sv
// One character slot of the scanline sprite engine.
// Holds the shadow row/x/valid written during the hblank fetch, promotes them to the
// active copy at end of line, and produces the registered per-pixel hit flag.
// Ports:
//   clk_i, reset_i  pixel clock, synchronous active-high reset
//   load_i          write the shadow registers this cycle (slot selected in FETCH)
//   hit_i           the fetched row lies inside the sprite (and slot is enabled)
//   row_i, x_i      ROM row and live x position to capture
//   promote_i       copy shadow to active (end of line)
//   draw_x_i        current pixel column
//   blank_i         current pixel outside the visible window
//   on_o            pixel lit, one cycle after draw_x_i
module sprite_slot
    import pacman_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic        hit_i,
    input  logic [31:0] row_i,
    input  logic [9:0]  x_i,
    input  logic        promote_i,
    input  logic [9:0]  draw_x_i,
    input  logic        blank_i,
    output logic        on_o
);

    logic [31:0] shadow_row_q, shadow_row_d;
    logic [9:0]  shadow_x_q, shadow_x_d;
    logic        shadow_vld_q, shadow_vld_d;
    logic [31:0] active_row_q, active_row_d;
    logic [9:0]  active_x_q, active_x_d;
    logic        active_vld_q, active_vld_d;
    logic        on_q, on_d;

    logic [10:0] col;
    logic        lit;

    always_comb begin
        shadow_row_d = shadow_row_q;
        shadow_x_d   = shadow_x_q;
        shadow_vld_d = shadow_vld_q;
        if (load_i) begin
            // A miss stores an empty row so stale data never reaches the screen.
            shadow_row_d = hit_i ? row_i : 32'd0;
            shadow_vld_d = hit_i;
            shadow_x_d   = x_i;
        end
    end

    always_comb begin
        active_row_d = active_row_q;
        active_x_d   = active_x_q;
        active_vld_d = active_vld_q;
        if (promote_i) begin
            active_row_d = shadow_row_q;
            active_x_d   = shadow_x_q;
            active_vld_d = shadow_vld_q;
        end
    end

    // Column 0 of the sprite is the row MSB.
    always_comb begin
        col  = sprite_offset(draw_x_i, active_x_q);
        lit  = active_vld_q && in_sprite(col) && active_row_q[5'd31 - col[4:0]];
        on_d = lit && !blank_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shadow_row_q <= '0;
            shadow_x_q   <= '0;
            shadow_vld_q <= 1'b0;
            active_row_q <= '0;
            active_x_q   <= '0;
            active_vld_q <= 1'b0;
            on_q         <= 1'b0;
        end else begin
            shadow_row_q <= shadow_row_d;
            shadow_x_q   <= shadow_x_d;
            shadow_vld_q <= shadow_vld_d;
            active_row_q <= active_row_d;
            active_x_q   <= active_x_d;
            active_vld_q <= active_vld_d;
            on_q         <= on_d;
        end
    end

    assign on_o = on_q;

endmodule

// File: rtl/sprite_line_fetcher.sv
// Scanline sprite engine: during each hblank fetches the next line's sprite row for
// Pac-Man and every ghost from the sprite ROM, then promotes them at end of line and
// emits registered per-pixel hit flags during active video.
// Ports:
//   Clk, Reset        pixel clock, synchronous active-high reset
//   DrawX, DrawY      current VGA pixel column / row
//   pac_x, pac_y      Pac-Man top-left; pac_dir selects the sprite bank
//   ghost_x, ghost_y  packed ghost top-left corners, slot 0 in the LSBs
//   ghost_en          per-ghost display enable
//   rom_addr          sprite ROM row address (0 outside FETCH)
//   rom_data          ROM row, combinational in the same cycle
//   pac_on, ghost_on  pixel hit flags, one cycle behind DrawX/DrawY
//   fetch_busy        FSM is in FETCH
module sprite_line_fetcher
    import pacman_pkg::*;
#(
    parameter int unsigned NUM_GHOSTS = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    input  logic [9:0]              pac_x,
    input  logic [9:0]              pac_y,
    input  logic [1:0]              pac_dir,
    input  logic [NUM_GHOSTS*10-1:0] ghost_x,
    input  logic [NUM_GHOSTS*10-1:0] ghost_y,
    input  logic [NUM_GHOSTS-1:0]   ghost_en,
    output logic [7:0]              rom_addr,
    input  logic [31:0]             rom_data,
    output logic                    pac_on,
    output logic [NUM_GHOSTS-1:0]   ghost_on,
    output logic                    fetch_busy
);

    localparam int unsigned NUM_SLOTS = NUM_GHOSTS + 1;
    localparam logic [2:0]  LAST_SLOT = 3'(NUM_GHOSTS);

    fetch_state_t state_q, state_d;
    logic [2:0]   slot_q, slot_d;

    logic [9:0]  next_y;
    logic [9:0]  sel_x;
    logic [9:0]  sel_y;
    logic        sel_en;
    logic [10:0] row_off;
    logic        row_hit;
    logic        promote;
    logic        blank;

    logic [NUM_SLOTS-1:0] slot_on;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        case (state_q)
            StIdle: begin
                if (DrawX == 10'(H_ACTIVE)) begin
                    state_d = StFetch;
                    slot_d  = '0;
                end
            end
            StFetch: begin
                slot_d = slot_q + 3'd1;
                if (slot_q == LAST_SLOT) begin
                    state_d = StWait;
                    slot_d  = '0;
                end
            end
            StWait: begin
                if (DrawX == 10'(H_TOTAL - 1)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                slot_d  = '0;
            end
        endcase
    end

    // Position and enable of the slot being fetched; slot 0 is Pac-Man.
    always_comb begin
        sel_x  = pac_x;
        sel_y  = pac_y;
        sel_en = 1'b1;
        for (int g = 0; g < int'(NUM_GHOSTS); g++) begin
            if (slot_q == 3'(g + 1)) begin
                sel_x  = ghost_x[g*10 +: 10];
                sel_y  = ghost_y[g*10 +: 10];
                sel_en = ghost_en[g];
            end
        end
    end

    always_comb begin
        next_y  = next_line(DrawY);
        row_off = sprite_offset(next_y, sel_y);
        row_hit = sel_en && in_sprite(row_off);
        promote = (state_q == StWait) && (DrawX == 10'(H_TOTAL - 1));
        blank   = (DrawX >= 10'(H_ACTIVE)) || (DrawY >= 10'(V_ACTIVE));
    end

    // Output logic.
    always_comb begin
        rom_addr   = '0;
        fetch_busy = 1'b0;
        if (state_q == StFetch) begin
            fetch_busy = 1'b1;
            if (slot_q == 3'd0) begin
                rom_addr = SPR_BASE_PAC + {1'b0, pac_dir, row_off[4:0]};
            end else begin
                rom_addr = SPR_BASE_GHOST + {3'b000, row_off[4:0]};
            end
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        sprite_slot u_slot (
            .clk_i     (Clk),
            .reset_i   (Reset),
            .load_i    (fetch_busy && (slot_q == 3'(i))),
            .hit_i     (row_hit),
            .row_i     (rom_data),
            .x_i       (sel_x),
            .promote_i (promote),
            .draw_x_i  (DrawX),
            .blank_i   (blank),
            .on_o      (slot_on[i])
        );
    end

    assign pac_on   = slot_on[0];
    assign ghost_on = slot_on[NUM_SLOTS-1:1];

endmodule
